// File: rtl/ram_bank.sv
// Single-port synchronous data RAM with byte-lane writes, selectable read-during-write
// behaviour, a post-reset clear sequencer and a req/rvalid handshake with range checking.
module ram_bank #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 11,
  parameter int unsigned DEPTH        = 2048,
  parameter int unsigned RD_MODE      = 0,
  parameter int unsigned CLEAR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                wen,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   din,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  output logic                busy,
  output logic                err
);

  localparam int unsigned       LANES   = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clr_addr;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                in_range;
  logic                acc_we;
  logic                clr_we;
  logic [DATA_W-1:0]   old_word;
  logic [DATA_W-1:0]   new_word;

  always_comb begin
    in_range = {1'b0, addr} < DEPTH_L;
    accept   = req && !busy;
    old_word = '0;
    if (in_range) old_word = mem[addr];
    new_word = old_word;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (be[i]) new_word[8*i +: 8] = din[8*i +: 8];
    end
    acc_we = !rst && accept && wen && in_range;
    clr_we = !rst && (state == CLEAR) && (CLEAR_ON_RST != 0);
  end

  // Storage carries no reset so contents survive rst when the clear walk is disabled.
  always_ff @(posedge clk) begin
    if (clr_we)      mem[clr_addr] <= '0;
    else if (acc_we) mem[addr]     <= new_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
      rdata    <= '0;
      rvalid   <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          rvalid <= 1'b0;
          err    <= 1'b0;
          if (CLEAR_ON_RST == 0) begin
            state <= READY;
            busy  <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
            if (clr_addr == LAST) begin
              state <= READY;
              busy  <= 1'b0;
            end
          end
        end
        READY: begin
          rvalid <= accept;
          err    <= accept && !in_range;
          if (accept) begin
            if (!in_range)                   rdata <= '0;
            else if (wen && (RD_MODE == 0))  rdata <= new_word;
            else                             rdata <= old_word;
          end
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bank.sv
// Directed bench for ram_bank: three instances cover write-first with clear,
// read-first without clear, and a non-power-of-two depth with out-of-range accesses.
module tb_ram_bank;

  logic        clk = 1'b0;
  logic        rst0, rst1, rst2;
  logic        req0, req1, req2;
  logic        wen;
  logic [3:0]  be;
  logic [3:0]  addr;
  logic [31:0] din;

  logic [31:0] rdata0, rdata1, rdata2;
  logic        rvalid0, rvalid1, rvalid2;
  logic        busy0, busy1, busy2;
  logic        err0, err1, err2;

  int checks   = 0;
  int failures = 0;
  int n;

  always #5 clk = ~clk;

  ram_bank #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_MODE(0), .CLEAR_ON_RST(1)) u0 (
    .clk(clk), .rst(rst0), .req(req0), .wen(wen), .be(be), .addr(addr), .din(din),
    .rdata(rdata0), .rvalid(rvalid0), .busy(busy0), .err(err0));

  ram_bank #(.DATA_W(32), .ADDR_W(4), .DEPTH(16), .RD_MODE(1), .CLEAR_ON_RST(0)) u1 (
    .clk(clk), .rst(rst1), .req(req1), .wen(wen), .be(be), .addr(addr), .din(din),
    .rdata(rdata1), .rvalid(rvalid1), .busy(busy1), .err(err1));

  ram_bank #(.DATA_W(32), .ADDR_W(4), .DEPTH(12), .RD_MODE(0), .CLEAR_ON_RST(1)) u2 (
    .clk(clk), .rst(rst2), .req(req2), .wen(wen), .be(be), .addr(addr), .din(din),
    .rdata(rdata2), .rvalid(rvalid2), .busy(busy2), .err(err2));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [3:0] b, input logic [3:0] a, input logic [31:0] d);
    wen = w; be = b; addr = a; din = d;
  endtask

  // Counts edges until u0 deasserts busy, holding a write request the whole time.
  task automatic wait_clear0(output int edges, output int saw_rvalid);
    edges = 0;
    saw_rvalid = 0;
    do begin
      tick();
      edges++;
      if (rvalid0) saw_rvalid++;
    end while (busy0 && edges < 40);
  endtask

  initial begin
    int sv;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    req0 = 1'b0; req1 = 1'b0; req2 = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 32'h0);

    tick();
    check("rst_busy0",   32'(busy0),   32'd1);
    check("rst_rvalid0", 32'(rvalid0), 32'd0);
    check("rst_rdata0",  rdata0,       32'h0);
    check("rst_err0",    32'(err0),    32'd0);
    check("rst_busy1",   32'(busy1),   32'd1);
    tick();
    check("rst_held_busy0", 32'(busy0), 32'd1);

    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    tick();
    check("noclr_busy1_low", 32'(busy1), 32'd0);
    n = 1;
    while (busy0 && n < 40) begin
      tick();
      n++;
    end
    check("init_clear_edges", 32'(n), 32'd16);
    check("u2_ready", 32'(busy2), 32'd0);

    // Fill u0 with all-ones so the next clear walk is observable.
    req0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 4'hF, 4'(i), 32'hFFFF_FFFF);
      tick();
    end
    drive(1'b0, 4'h0, 4'd9, 32'h0);
    tick();
    check("preload_rd9", rdata0, 32'hFFFF_FFFF);
    req0 = 1'b0;

    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("midclear_busy", 32'(busy0), 32'd1);
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    req0 = 1'b1;
    drive(1'b1, 4'hF, 4'd2, 32'hDEAD_BEEF);
    wait_clear0(n, sv);
    req0 = 1'b0;
    check("restart_clear_edges", 32'(n), 32'd16);
    check("busy_no_rvalid", 32'(sv), 32'd0);

    req0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 4'h0, 4'(i), 32'h0);
      tick();
      check($sformatf("clr_rvalid%0d", i), 32'(rvalid0), 32'd1);
      check($sformatf("clr_rdata%0d", i),  rdata0,       32'h0);
    end

    drive(1'b1, 4'hF, 4'd5, 32'hAABB_CCDD);
    tick();
    check("bl_full_wf", rdata0, 32'hAABB_CCDD);
    drive(1'b1, 4'b0101, 4'd5, 32'h1122_3344);
    tick();
    check("bl_partial_wf", rdata0, 32'hAA22_CC44);
    drive(1'b0, 4'h0, 4'd5, 32'h0);
    tick();
    check("bl_read", rdata0, 32'hAA22_CC44);
    drive(1'b1, 4'h0, 4'd5, 32'h0);
    tick();
    check("be0_rvalid", 32'(rvalid0), 32'd1);
    check("be0_rdata",  rdata0,       32'hAA22_CC44);

    req1 = 1'b1;
    drive(1'b1, 4'hF, 4'd3, 32'h1234_5678);
    tick();
    drive(1'b1, 4'hF, 4'd3, 32'hCAFE_F00D);
    tick();
    check("rdw_write_first", rdata0, 32'hCAFE_F00D);
    check("rdw_read_first",  rdata1, 32'h1234_5678);
    check("rdw_rvalid1", 32'(rvalid1), 32'd1);
    drive(1'b0, 4'h0, 4'd3, 32'h0);
    tick();
    check("raw_u0", rdata0, 32'hCAFE_F00D);
    check("raw_u1", rdata1, 32'hCAFE_F00D);
    req1 = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'hF, 4'(i), 32'h100 + 32'(i));
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'h0, 4'(i), 32'h0);
      tick();
      check($sformatf("b2b_rvalid%0d", i), 32'(rvalid0), 32'd1);
      check($sformatf("b2b_rdata%0d", i),  rdata0,       32'h100 + 32'(i));
    end
    req0 = 1'b0;
    drive(1'b1, 4'hF, 4'd0, 32'h5555_5555);
    tick();
    check("idle_rvalid", 32'(rvalid0), 32'd0);
    check("idle_hold",   rdata0,       32'h107);
    req0 = 1'b1;
    drive(1'b0, 4'h0, 4'd0, 32'h0);
    tick();
    check("idle_nowrite", rdata0, 32'h100);
    req0 = 1'b0;

    req2 = 1'b1;
    drive(1'b0, 4'h0, 4'd11, 32'h0);
    tick();
    check("u2_clr11", rdata2, 32'h0);
    drive(1'b1, 4'hF, 4'd1, 32'h55AA_55AA);
    tick();
    check("u2_inrange_err", 32'(err2), 32'd0);
    drive(1'b1, 4'hF, 4'd13, 32'hFFFF_FFFF);
    tick();
    check("oor_err",    32'(err2),    32'd1);
    check("oor_rvalid", 32'(rvalid2), 32'd1);
    check("oor_rdata",  rdata2,       32'h0);
    drive(1'b0, 4'h0, 4'd1, 32'h0);
    tick();
    check("oor_rd1",     rdata2,       32'h55AA_55AA);
    check("oor_err_clr", 32'(err2),    32'd0);
    req2 = 1'b0;
    tick();
    check("u2_idle_rvalid", 32'(rvalid2), 32'd0);
    check("u2_idle_err",    32'(err2),    32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
